// File: rtl/trace_capture_ctrl_pkg.sv
// Shared types for the trace capture slice.
// - trace_output: the record produced by the trace unit.
// - capture_state_e: the capture-state encoding. It is exported on state_o.
package ryuki_datatypes;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [7:0]  info;
   } trace_output;

   typedef enum logic [2:0] {
      CAP_IDLE      = 3'd0,
      CAP_ARMED     = 3'd1,
      CAP_CAPTURING = 3'd2,
      CAP_DRAINING  = 3'd3,
      CAP_DONE      = 3'd4
   } capture_state_e;

   // A new window may only be armed from a quiescent state.
   function automatic logic arm_allowed(capture_state_e s);
      return (s == CAP_IDLE) || (s == CAP_DONE);
   endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Control, trace-in and drain-out signals of trace_capture_ctrl.
// The slave modport is the controller side; the master modport is the driver side.
// drop_count_o exists only when TRACE_CAPTURE_DROP_COUNT_EN is defined.
interface trace_capture_ctrl_if
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) ();
   import ryuki_datatypes::*;

   logic                  arm_i;
   logic                  disarm_i;
   logic [ADDR_WIDTH-1:0] trig_addr_i;
   logic [LEN_WIDTH-1:0]  capture_len_i;
   logic                  rec_valid_i;
   logic [ADDR_WIDTH-1:0] rec_addr_i;
   trace_output           rec_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   trace_output           out_rec_o;
   logic [2:0]            state_o;
   logic                  done_o;
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
   logic [LEN_WIDTH-1:0]  drop_count_o;
`endif

   modport slave (
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
      output drop_count_o,
`endif
      input  arm_i, disarm_i, trig_addr_i, capture_len_i,
      input  rec_valid_i, rec_addr_i, rec_i, out_ready_i,
      output out_valid_o, out_rec_o, state_o, done_o
   );

   modport master (
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
      input  drop_count_o,
`endif
      output arm_i, disarm_i, trig_addr_i, capture_len_i,
      output rec_valid_i, rec_addr_i, rec_i, out_ready_i,
      input  out_valid_o, out_rec_o, state_o, done_o
   );

endinterface

// File: rtl/trace_capture_ctrl_fifo.sv
// trace_fifo: capture buffer for trace records.
// - DEPTH must be a power of two, at least 2.
// - A pushed entry is readable the cycle after it is written.
// - dout_o reads all-zero while the buffer is empty.
// - When full, a push is accepted only if a pop happens in the same cycle.
// - flush_i empties the buffer in one cycle.
module trace_fifo
   import ryuki_datatypes::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        push_i,
   input  trace_output din_i,
   input  logic        pop_i,
   output trace_output dout_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);

   trace_output   mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);
   assign dout_o  = empty_o ? '0 : mem_q[rd_q];

   // next occupancy from the accepted push/pop pair
   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) cnt_d = cnt_q - (AW+1)'(1);
   end

   // pointer and occupancy registers; flush returns to empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

   // record storage, no reset needed: empty masks stale contents
   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: arms on a request, waits for a trigger address,
// captures a fixed-length window of trace records into trace_fifo,
// and drains the buffer to a ready/valid consumer.
// Build option TRACE_CAPTURE_DROP_COUNT_EN adds a saturating counter of
// records lost to a full buffer (drop_count_o).
module trace_capture_ctrl
   import ryuki_datatypes::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst,
   trace_capture_ctrl_if.slave bus
);
   capture_state_e        state_q;
   logic [LEN_WIDTH-1:0]  rem_q;
   logic                  done_q;

   logic [ADDR_WIDTH-1:0] trig_addr;
   logic                  arm_ok, trig_hit, cap_take;
   logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
   trace_output           fifo_dout;

   assign trig_addr = bus.trig_addr_i;
   assign trig_hit  = bus.rec_valid_i && (bus.rec_addr_i == trig_addr);
   assign arm_ok    = bus.arm_i && !bus.disarm_i && arm_allowed(state_q)
                      && (bus.capture_len_i != '0);
   // a record belongs to the window: the trigger itself, or any valid record while capturing
   assign cap_take  = !bus.disarm_i &&
                      (((state_q == CAP_CAPTURING) && bus.rec_valid_i) ||
                       ((state_q == CAP_ARMED) && trig_hit));
   assign fifo_pop  = !fifo_empty && bus.out_ready_i;
   // a full buffer takes the record only if it frees a slot this cycle
   assign fifo_push = cap_take && (!fifo_full || fifo_pop);

   trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.disarm_i),
      .push_i  (fifo_push),
      .din_i   (bus.rec_i),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // capture window sequencing; disarm overrides every other request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CAP_IDLE;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else if (bus.disarm_i) begin
         state_q <= CAP_IDLE;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            CAP_IDLE, CAP_DONE: begin
               if (arm_ok) begin
                  state_q <= CAP_ARMED;
                  rem_q   <= bus.capture_len_i;
                  done_q  <= 1'b0;
               end
            end
            CAP_ARMED, CAP_CAPTURING: begin
               // dropped records still consume window length
               if (cap_take) begin
                  rem_q   <= rem_q - LEN_WIDTH'(1);
                  state_q <= (rem_q == LEN_WIDTH'(1)) ? CAP_DRAINING : CAP_CAPTURING;
               end
            end
            CAP_DRAINING: begin
               if (fifo_empty) begin
                  state_q <= CAP_DONE;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= CAP_IDLE;
               rem_q   <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef TRACE_CAPTURE_DROP_COUNT_EN
   logic [LEN_WIDTH-1:0] drop_q;
   logic                 rec_drop;

   assign rec_drop = cap_take && !fifo_push;

   // per-window count of records lost to a full buffer, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          drop_q <= '0;
      else if (arm_ok)                  drop_q <= '0;
      else if (rec_drop && drop_q != '1) drop_q <= drop_q + LEN_WIDTH'(1);
   end

   assign bus.drop_count_o = drop_q;
`endif

   assign bus.out_valid_o = !fifo_empty;
   assign bus.out_rec_o   = fifo_dout;
   assign bus.state_o     = state_q;
   assign bus.done_o      = done_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed + random bench for trace_capture_ctrl.
// A queue-based reference model predicts state, buffer head and done.
// If TRACE_CAPTURE_DROP_COUNT_EN is defined, it also predicts the drop count.
module tb_trace_capture_ctrl;
   import ryuki_datatypes::*;

   localparam int AW    = 32;
   localparam int DEPTH = 16;
   localparam int LW    = 16;
   localparam int MAXD  = (1 << LW) - 1;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   trace_capture_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   trace_capture_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference model: window state, remaining length, buffer contents
   capture_state_e m_st;
   int             m_rem;
   int             m_drops;
   bit             m_done;
   trace_output    m_q[$];
   logic [31:0]    pop_log[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = CAP_IDLE; m_rem = 0; m_drops = 0; m_done = 1'b0;
      m_q.delete();
   endtask

   task automatic model_update();
      int pre;
      bit take;
      pre = m_q.size();
      if (bus.disarm_i) begin
         model_reset();
         return;
      end
      if (pre != 0 && bus.out_ready_i) void'(m_q.pop_front());
      take = bus.rec_valid_i &&
             (m_st == CAP_CAPTURING || (m_st == CAP_ARMED && bus.rec_addr_i == bus.trig_addr_i));
      if (take) begin
         if (m_q.size() < DEPTH) m_q.push_back(bus.rec_i);
         else if (m_drops < MAXD) m_drops++;
         m_rem--;
         m_st = (m_rem == 0) ? CAP_DRAINING : CAP_CAPTURING;
      end else if ((m_st == CAP_IDLE || m_st == CAP_DONE) && bus.arm_i && bus.capture_len_i != 0) begin
         m_st = CAP_ARMED; m_rem = int'(bus.capture_len_i); m_drops = 0; m_done = 1'b0;
      end else if (m_st == CAP_DRAINING && pre == 0) begin
         m_st = CAP_DONE; m_done = 1'b1;
      end
   endtask

   // compare outputs against the model, advance the model, move one clock
   task automatic step();
      trace_output exp_rec;
      exp_rec = (m_q.size() != 0) ? m_q[0] : '0;
      chk("state", bus.state_o, m_st);
      chk("out_valid", bus.out_valid_o, m_q.size() != 0);
      chk("out_rec", bus.out_rec_o, exp_rec);
      chk("done", bus.done_o, m_done);
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
      chk("drop_count", bus.drop_count_o, m_drops);
`endif
      if (bus.out_valid_o && bus.out_ready_i) pop_log.push_back(bus.out_rec_o.pc);
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic arm(input int len, input logic [31:0] trig);
      bus.arm_i = 1'b1; bus.capture_len_i = LW'(len); bus.trig_addr_i = trig;
      step();
      bus.arm_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] a);
      bus.rec_valid_i = 1'b1; bus.rec_addr_i = a;
      bus.rec_i = '{pc: a, insn: $urandom(), info: 8'($urandom())};
      step();
      bus.rec_valid_i = 1'b0;
   endtask

   task automatic run_until_done(input string tag, input int max);
      for (int i = 0; i < max && !bus.done_o; i++) step();
      chk(tag, bus.done_o, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish within 500000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      logic [31:0] trig;
      logic [31:0] a;

      rst = 1'b1;
      bus.arm_i = 1'b0; bus.disarm_i = 1'b0; bus.trig_addr_i = '0; bus.capture_len_i = '0;
      bus.rec_valid_i = 1'b0; bus.rec_addr_i = '0; bus.rec_i = '0; bus.out_ready_i = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_state", bus.state_o, CAP_IDLE);
      chk("rst_valid", bus.out_valid_o, 1'b0);
      chk("rst_rec", bus.out_rec_o, '0);
      chk("rst_done", bus.done_o, 1'b0);
      rst = 1'b0;
      step();

      // basic window: trigger at 0x100, length 4, consumer always ready
      bus.out_ready_i = 1'b1;
      arm(4, 32'h100);
      base = pop_log.size();
      send(32'h0FC); send(32'h100); send(32'h104); send(32'h108); send(32'h10C);
      run_until_done("s1_done", 20);
      chk("s1_pops", pop_log.size() - base, 4);
      for (int i = 0; i < 4; i++)
         chk("s1_order", (base + i < pop_log.size()) ? pop_log[base + i] : 32'hFFFF_FFFF, 32'h100 + 4 * i);
      chk("s1_state", bus.state_o, CAP_DONE);

      // overflow: len 20 into a 16-deep buffer with a stalled consumer
      bus.out_ready_i = 1'b0;
      trig = 32'h2000;
      arm(20, trig);
      for (int i = 0; i < 20; i++) send(trig + 32'(4 * i));
      chk("s2_draining", bus.state_o, CAP_DRAINING);
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
      chk("s2_drops", bus.drop_count_o, 4);
`endif
      bus.out_ready_i = 1'b1;
      base = pop_log.size();
      run_until_done("s2_done", 40);
      chk("s2_pops", pop_log.size() - base, 16);

      // full buffer with simultaneous push and pop keeps all 16 entries
      bus.out_ready_i = 1'b0;
      arm(20, trig);
      for (int i = 0; i < 16; i++) send(trig + 32'(4 * i));
      bus.out_ready_i = 1'b1;
      send(32'h3000);
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
      chk("s3_no_drop", bus.drop_count_o, 0);
`endif
      base = pop_log.size();
      for (int i = 0; i < 40 && bus.out_valid_o; i++) step();
      chk("s3_occupancy", pop_log.size() - base, 16);
      chk("s3_last", (pop_log.size() != 0) ? pop_log[pop_log.size() - 1] : 32'h0, 32'h3000);
      send(32'h3004); send(32'h3008); send(32'h300C);
      run_until_done("s3_done", 20);

      // disarm mid-capture with 5 records buffered
      bus.out_ready_i = 1'b0;
      arm(10, trig);
      for (int i = 0; i < 5; i++) send(trig + 32'(4 * i));
      chk("s4_capturing", bus.state_o, CAP_CAPTURING);
      bus.disarm_i = 1'b1;
      step();
      bus.disarm_i = 1'b0;
      chk("s4_idle", bus.state_o, CAP_IDLE);
      chk("s4_valid", bus.out_valid_o, 1'b0);
      bus.out_ready_i = 1'b1;
      base = pop_log.size();
      for (int i = 0; i < 5; i++) step();
      chk("s4_no_pops", pop_log.size() - base, 0);

      // disarm wins over a simultaneous arm in IDLE
      bus.disarm_i = 1'b1; bus.arm_i = 1'b1; bus.capture_len_i = 16'd3;
      step();
      bus.disarm_i = 1'b0; bus.arm_i = 1'b0;
      chk("s4_prio", bus.state_o, CAP_IDLE);

      // asynchronous reset while draining, then a zero-length arm
      bus.out_ready_i = 1'b0;
      arm(18, trig);
      for (int i = 0; i < 18; i++) send(trig + 32'(4 * i));
      step();
      chk("s5_draining", bus.state_o, CAP_DRAINING);
      #2 rst = 1'b1;
      #1;
      chk("s5_rst_state", bus.state_o, CAP_IDLE);
      chk("s5_rst_valid", bus.out_valid_o, 1'b0);
      chk("s5_rst_rec", bus.out_rec_o, '0);
      chk("s5_rst_done", bus.done_o, 1'b0);
`ifdef TRACE_CAPTURE_DROP_COUNT_EN
      chk("s5_rst_drops", bus.drop_count_o, 0);
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      step();
      arm(0, trig);
      step(); step();
      chk("s5_len0_idle", bus.state_o, CAP_IDLE);

      // random traffic against the model
      trig = 32'h0000_4000;
      bus.trig_addr_i = trig;
      for (int c = 0; c < 400; c++) begin
         bus.arm_i         = ($urandom_range(0, 15) == 0);
         bus.capture_len_i = LW'($urandom_range(0, 24));
         bus.disarm_i      = ($urandom_range(0, 63) == 0);
         bus.rec_valid_i   = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? trig : 32'h1000 + 32'(4 * $urandom_range(0, 31));
         bus.rec_addr_i    = a;
         bus.rec_i         = '{pc: a, insn: $urandom(), info: 8'($urandom())};
         bus.out_ready_i   = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step();
      end
      bus.arm_i = 1'b0; bus.disarm_i = 1'b0; bus.rec_valid_i = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of traced instruction address.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: capture buffer entries; power of 2, at least 2.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of capture length and drop counter.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port arm_i  input  1  single-cycle request to start a capture window.
REQ-007 SHALL have port disarm_i  input  1  abort; return to idle and flush.
REQ-008 SHALL have port trig_addr_i  input  ADDR_WIDTH  trigger instruction address.
REQ-009 SHALL have port capture_len_i  input  LEN_WIDTH  number of records per window.
REQ-010 SHALL have port rec_valid_i  input  1  trace record present this cycle.
REQ-011 SHALL have port rec_addr_i  input  ADDR_WIDTH  instruction address of the presented record.
REQ-012 SHALL have port rec_i  input  trace_output  trace record from the trace unit.
REQ-013 SHALL have port out_valid_o  output  1  buffered record available.
REQ-014 SHALL have port out_ready_i  input  1  consumer accepts out_rec_o.
REQ-015 SHALL have port out_rec_o  output  trace_output  head-of-buffer record.
REQ-016 SHALL have port state_o  output  3  current capture state encoding.
REQ-017 SHALL have port done_o  output  1  window complete and buffer drained.

Function
REQ-018 SHALL implement the states IDLE, ARMED, CAPTURING, DRAINING and DONE.
REQ-019 SHALL, on arm_i in IDLE or DONE with capture_len_i nonzero, latch capture_len_i into the remaining-count register and enter ARMED next cycle; arm_i with capture_len_i of 0, or arm_i in any other state, SHALL be ignored.
REQ-020 SHALL, in ARMED, stay put until rec_valid_i with rec_addr_i == trig_addr_i; that record is the first captured and the state becomes CAPTURING (DRAINING if the length is 1).
REQ-021 SHALL, in CAPTURING, push each rec_valid_i record and decrement the remaining count; the record that brings the count to 0 moves the state to DRAINING.
REQ-022 SHALL, when the buffer is full and no pop occurs the same cycle, drop the record; a dropped record still decrements the remaining count.
REQ-023 SHALL, when the buffer is full and a pop occurs the same cycle, accept the push.
REQ-024 SHALL make a pushed record visible on out_valid_o/out_rec_o at the next cycle at the earliest (1-cycle latency), in FIFO order.
REQ-025 SHALL pop on out_valid_o && out_ready_i in any state; out_rec_o SHALL hold stable while out_valid_o && !out_ready_i.
REQ-026 SHALL, in DRAINING, enter DONE in the cycle after the buffer becomes empty; done_o is high only in DONE.
REQ-027 SHALL, on disarm_i in any state, flush the buffer, drive out_valid_o low next cycle and enter IDLE; disarm_i takes priority over a simultaneous arm_i.
REQ-028 SHALL treat records with rec_valid_i low as absent, and SHALL ignore records in IDLE, ARMED (non-matching), DRAINING and DONE.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, an empty buffer, remaining count 0, out_valid_o 0, out_rec_o all-zero, done_o 0, state_o the IDLE encoding, and drop_count_o 0 when present.
REQ-030 SHALL, on reset asserted mid-capture, discard all buffered records; no partial window resumes.

Configuration
REQ-031 SHALL, with TRACE_CAPTURE_DROP_COUNT_EN defined, add output drop_count_o of LEN_WIDTH bits; it counts records dropped per REQ-022, saturates at all-ones, and clears on an accepted arm_i.
REQ-032 SHALL, without TRACE_CAPTURE_DROP_COUNT_EN, have no drop_count_o port and no counter logic; drop behaviour is otherwise identical.

Structure
REQ-033 SHALL take trace_output from ryuki_datatypes, and SHALL define the capture-state enum (3-bit encoding, consumed by state_o) in ryuki_datatypes.
REQ-034 SHALL implement the buffer as a sub-module trace_fifo (parameterised depth, push/pop/full/empty/flush), instantiated once.

Verification
REQ-035 SHALL cover: arm with len 4, trig 0x100; records at 0x0FC, 0x100, 0x104, 0x108, 0x10C with out_ready_i=1 -> 4 records out in order starting with 0x100, then DONE, done_o=1.
REQ-036 SHALL cover: DEPTH 16, len 20, out_ready_i=0 throughout -> 16 records buffered, 4 dropped, drop_count_o=4 (macro on), DRAINING; raising out_ready_i -> 16 pops, then DONE.
REQ-037 SHALL cover: full buffer with push and pop in the same cycle -> push accepted, no drop, occupancy stays 16.
REQ-038 SHALL cover: disarm_i during CAPTURING with 5 records buffered -> IDLE and out_valid_o=0 next cycle, and no further pops.
REQ-039 SHALL cover: rst asserted asynchronously mid-DRAINING -> outputs at reset values immediately; arm_i with capture_len_i=0 afterwards -> remains IDLE.
